// File: rtl/alu_operand_loader_if.sv
// Pin-side and ALU-side signal bundle for the ALU operand loader.
// Handshake: there is no ready path; each rising edge of the pin-driven
// `load` strobe delivers one nibble on data_in (A/B first, opcode second),
// and `valid` marks result_q/carry_q as holding the latest completed result.
interface alu_operand_loader_if;
   logic       load;
   logic [3:0] data_in;
   logic [1:0] alu_a;
   logic [1:0] alu_b;
   logic [3:0] alu_sel;
   logic [6:0] alu_result;
   logic       alu_carry;
   logic [6:0] result_q;
   logic       carry_q;
   logic       valid;
   logic       busy;
   logic       timeout_err;
   logic [1:0] state;   // debug view of the loader FSM state

   modport slave (
      input  load, data_in, alu_result, alu_carry,
      output alu_a, alu_b, alu_sel, result_q, carry_q, valid, busy,
             timeout_err, state
   );

   modport master (
      output load, data_in, alu_result, alu_carry,
      input  alu_a, alu_b, alu_sel, result_q, carry_q, valid, busy,
             timeout_err, state
   );
endinterface

// File: rtl/alu_operand_loader.sv
// Two-nibble operand/opcode loader for the 2-bit ALU: synchronises the slow
// pin strobe, captures A/B then opcode, samples the ALU result one cycle
// later and holds it with a valid flag. Abandoned transactions time out.
module alu_operand_loader #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input logic                  clk,
   input logic                  reset,
   alu_operand_loader_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, GOT_OPS, EXEC, DONE} state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic             load_s1, load_s2, load_s3;
   logic [3:0]       data_s1, data_s2;
   logic [1:0]       fill;
   logic             armed;
   logic             strobe;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       alu_a, alu_b;
   logic [3:0]       alu_sel;
   logic [6:0]       result_q;
   logic             carry_q, valid, busy, timeout_err;

   // Synchronise the pin inputs and arm edge detection once a real low is seen.
   // Reset clears the flops to 0, which would look like a low level; `fill`
   // waits until load_s2 holds a genuinely sampled pin value before arming,
   // so a load held high through reset release cannot fake a rising edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_s1 <= 1'b0;
         load_s2 <= 1'b0;
         load_s3 <= 1'b0;
         data_s1 <= '0;
         data_s2 <= '0;
         fill    <= '0;
         armed   <= 1'b0;
      end else begin
         load_s1 <= bus.load;
         load_s2 <= load_s1;
         load_s3 <= load_s2;
         data_s1 <= bus.data_in;
         data_s2 <= data_s1;
         fill    <= {fill[0], 1'b1};
         if (fill[1] && !load_s2)
            armed <= 1'b1;
      end
   end

   assign strobe = load_s2 & ~load_s3 & armed;

   // Transaction FSM; every output is registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_sel     <= '0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         valid       <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (strobe) begin
                  alu_a       <= data_s2[3:2];
                  alu_b       <= data_s2[1:0];
                  timeout_err <= 1'b0;
                  cnt         <= '0;
                  busy        <= 1'b1;
                  state       <= GOT_OPS;
                  // Leaving DONE starts a new result, so the old one is stale.
                  if (state == DONE)
                     valid <= 1'b0;
               end
            end
            GOT_OPS: begin
               // A strobe on the timeout cycle still completes the transaction.
               if (strobe) begin
                  alu_sel <= data_s2;
                  state   <= EXEC;
               end else if (cnt == TIMEOUT_LAST) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            EXEC: begin
               // ALU inputs have been stable since the opcode edge.
               result_q <= bus.alu_result;
               carry_q  <= bus.alu_carry;
               valid    <= 1'b1;
               busy     <= 1'b0;
               state    <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.alu_a       = alu_a;
   assign bus.alu_b       = alu_b;
   assign bus.alu_sel     = alu_sel;
   assign bus.result_q    = result_q;
   assign bus.carry_q     = carry_q;
   assign bus.valid       = valid;
   assign bus.busy        = busy;
   assign bus.timeout_err = timeout_err;
   assign bus.state       = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with a small ALU stub:
// sel 0 add, 1 subtract (carry = borrow), 2 multiply, 3 and, else xor.
module tb_alu_operand_loader;

   localparam int TO       = 16;
   localparam int ST_IDLE  = 0;
   localparam int ST_GOT   = 1;
   localparam int ST_EXEC  = 2;
   localparam int ST_DONE  = 3;

   typedef struct {
      logic [3:0] n1;
      logic [3:0] n2;
      logic [1:0] exp_a;
      logic [1:0] exp_b;
      logic [3:0] exp_sel;
      logic [6:0] exp_r;
      logic       exp_c;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [1:0] prev_state = 2'd0;
   vec_t       vecs[5];

   alu_operand_loader_if bus();

   alu_operand_loader #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock
   always #5 clk = ~clk;

   // ALU stub
   always_comb begin
      logic [6:0] ea, eb;
      ea = {5'b0, bus.alu_a};
      eb = {5'b0, bus.alu_b};
      bus.alu_carry = 1'b0;
      case (bus.alu_sel)
         4'd0: bus.alu_result = ea + eb;
         4'd1: begin
            bus.alu_result = ea - eb;
            bus.alu_carry  = (bus.alu_a < bus.alu_b);
         end
         4'd2: bus.alu_result = ea * eb;
         4'd3: bus.alu_result = ea & eb;
         default: bus.alu_result = ea ^ eb;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Raise load with a nibble; return just after the edge where the strobe acts.
   task automatic strobe_nibble(input logic [3:0] d);
      @(negedge clk);
      bus.data_in = d;
      bus.load    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic release_load();
      @(negedge clk);
      bus.load = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_alu_a"},  32'(bus.alu_a), 0);
      check({tag, "_alu_b"},  32'(bus.alu_b), 0);
      check({tag, "_alu_sel"}, 32'(bus.alu_sel), 0);
      check({tag, "_result"}, 32'(bus.result_q), 0);
      check({tag, "_carry"},  32'(bus.carry_q), 0);
      check({tag, "_valid"},  32'(bus.valid), 0);
      check({tag, "_busy"},   32'(bus.busy), 0);
      check({tag, "_terr"},   32'(bus.timeout_err), 0);
      check({tag, "_state"},  32'(bus.state), ST_IDLE);
   endtask

   // scoreboard: compare each freshly completed result against the queue
   always @(negedge clk) begin
      if (bus.state == 2'(ST_DONE) && prev_state != 2'(ST_DONE)) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            check("sb_result", 32'({bus.carry_q, bus.result_q}), 32'(exp_q.pop_front()));
            check("sb_valid", 32'(bus.valid), 1);
         end
      end
      prev_state <= bus.state;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{4'b1110, 4'b0000, 2'd3, 2'd2, 4'd0, 7'd5,   1'b0};
      vecs[1] = '{4'b1111, 4'b0010, 2'd3, 2'd3, 4'd2, 7'd9,   1'b0};
      vecs[2] = '{4'b0110, 4'b0001, 2'd1, 2'd2, 4'd1, 7'h7f,  1'b1};
      vecs[3] = '{4'b1001, 4'b0011, 2'd2, 2'd1, 4'd3, 7'd0,   1'b0};
      vecs[4] = '{4'b1011, 4'b1111, 2'd2, 2'd3, 4'd15, 7'd1,  1'b0};

      // reset
      reset       = 1'b1;
      bus.load    = 1'b0;
      bus.data_in = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // table-driven transactions, back to back from DONE after the first
      for (int i = 0; i < 5; i++) begin
         strobe_nibble(vecs[i].n1);
         check("v_state_got", 32'(bus.state), ST_GOT);
         check("v_alu_a", 32'(bus.alu_a), 32'(vecs[i].exp_a));
         check("v_alu_b", 32'(bus.alu_b), 32'(vecs[i].exp_b));
         check("v_busy1", 32'(bus.busy), 1);
         check("v_valid_drop", 32'(bus.valid), 0);
         if (i > 0)
            check("v_result_held", 32'(bus.result_q), 32'(vecs[i-1].exp_r));
         exp_q.push_back({vecs[i].exp_c, vecs[i].exp_r});
         release_load();
         strobe_nibble(vecs[i].n2);
         check("v_state_exec", 32'(bus.state), ST_EXEC);
         check("v_alu_sel", 32'(bus.alu_sel), 32'(vecs[i].exp_sel));
         check("v_busy2", 32'(bus.busy), 1);
         @(posedge clk);
         #1;
         check("v_result", 32'(bus.result_q), 32'(vecs[i].exp_r));
         check("v_carry", 32'(bus.carry_q), 32'(vecs[i].exp_c));
         check("v_valid", 32'(bus.valid), 1);
         check("v_busy_done", 32'(bus.busy), 0);
         release_load();
      end

      // timeout: single nibble then nothing
      strobe_nibble(4'b0110);
      for (int k = 1; k < TO; k++) begin
         @(posedge clk);
         #1;
         check("to_busy_hold", 32'(bus.busy), 1);
      end
      @(posedge clk);
      #1;
      check("to_state", 32'(bus.state), ST_IDLE);
      check("to_busy", 32'(bus.busy), 0);
      check("to_err", 32'(bus.timeout_err), 1);
      check("to_valid", 32'(bus.valid), 0);
      check("to_alu_a", 32'(bus.alu_a), 1);
      check("to_alu_b", 32'(bus.alu_b), 2);
      release_load();
      strobe_nibble(4'b1101);
      check("to_err_clear", 32'(bus.timeout_err), 0);
      check("to_restart", 32'(bus.state), ST_GOT);
      exp_q.push_back({1'b0, 7'd4});
      release_load();
      strobe_nibble(4'b0000);
      @(posedge clk);
      #1;
      check("to_after_result", 32'(bus.result_q), 4);
      release_load();

      // strobe coincident with timeout cycle
      strobe_nibble(4'b0101);
      exp_q.push_back({1'b0, 7'd2});
      @(negedge clk);
      bus.load = 1'b0;
      repeat (13) @(posedge clk);
      @(negedge clk);
      bus.data_in = 4'b0000;
      bus.load    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("co_still_got", 32'(bus.state), ST_GOT);
      @(posedge clk);
      #1;
      check("co_exec", 32'(bus.state), ST_EXEC);
      check("co_err", 32'(bus.timeout_err), 0);
      check("co_busy", 32'(bus.busy), 1);
      @(posedge clk);
      #1;
      check("co_valid", 32'(bus.valid), 1);
      check("co_result", 32'(bus.result_q), 2);
      release_load();

      // reset mid-transaction
      strobe_nibble(4'b1110);
      release_load();
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      strobe_nibble(4'b0000);
      check("midrst_got", 32'(bus.state), ST_GOT);
      check("midrst_a", 32'(bus.alu_a), 0);
      check("midrst_b", 32'(bus.alu_b), 0);
      exp_q.push_back({1'b0, 7'd0});
      release_load();
      strobe_nibble(4'b0000);
      check("midrst_exec", 32'(bus.state), ST_EXEC);
      release_load();

      // load held high through reset release
      @(negedge clk);
      bus.data_in = 4'b1110;
      bus.load    = 1'b1;
      reset       = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check("hold_state", 32'(bus.state), ST_IDLE);
      check("hold_busy", 32'(bus.busy), 0);
      check("hold_alu_a", 32'(bus.alu_a), 0);
      release_load();
      @(negedge clk);
      strobe_nibble(4'b1110);
      check("hold_capture", 32'(bus.state), ST_GOT);
      check("hold_a", 32'(bus.alu_a), 3);
      check("hold_b", 32'(bus.alu_b), 2);
      exp_q.push_back({1'b0, 7'd1});
      release_load();
      strobe_nibble(4'b0001);
      @(posedge clk);
      #1;
      check("hold_result", 32'(bus.result_q), 1);
      release_load();

      check("sb_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
